// File: rtl/mem_bus_master_pkg.sv
// Shared types for the system-bus master: default widths and the bus-cycle state encoding.
package mem_bus_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_ADDR,
        ST_XFER,
        ST_RESP
    } state_t;
endpackage

// File: rtl/mem_bus_master_if.sv
// Request/response and memory-control signals of the bus master; bus itself stays a plain inout.
// MEM_BUS_MASTER_AUTOINC_EN adds the req_inc request bit.
interface mem_bus_master_if
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
`ifdef MEM_BUS_MASTER_AUTOINC_EN
    logic              req_inc;
`endif
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              bus_req;
    logic              bus_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_oe;
    logic              mem_ie;

    modport master (
`ifdef MEM_BUS_MASTER_AUTOINC_EN
        input  req_inc,
`endif
        input  req_valid, req_we, req_addr, req_wdata, bus_gnt,
        output req_ready, rsp_valid, rsp_rdata, bus_req, mem_addr, mem_oe, mem_ie
    );

    modport slave (
`ifdef MEM_BUS_MASTER_AUTOINC_EN
        output req_inc,
`endif
        output req_valid, req_we, req_addr, req_wdata, bus_gnt,
        input  req_ready, rsp_valid, rsp_rdata, bus_req, mem_addr, mem_oe, mem_ie
    );
endinterface

// File: rtl/mem_bus_master_tristate.sv
// Purpose: the only tri-state driver on the shared bus; drives d when en, else releases to Z.
// Latency: combinational.
// Backpressure: none; en is expected to come straight from a register.
module bus_tristate_driver #(
    parameter int W = 8
) (
    input  logic         en,
    input  logic [W-1:0] d,
    inout  wire  [W-1:0] bus
);
    assign bus = en ? d : {W{1'bz}};
endmodule

// File: rtl/mem_bus_master.sv
// Purpose: turns single read/write requests into arbitrated memory bus cycles (IDLE-ARB-ADDR-XFER-RESP).
// Latency: accept at edge E, rsp_valid in the cycle after E+3 when grant is already high; ready again at E+4.
// Backpressure: req_ready low while a cycle is in flight, nothing queued. MEM_BUS_MASTER_AUTOINC_EN adds req_inc/ptr.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_master_if.master   mbus,
    inout  wire  [DATA_W-1:0]  bus
);
    state_t            state;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              drv_en;
    logic [ADDR_W-1:0] acc_addr;

`ifdef MEM_BUS_MASTER_AUTOINC_EN
    logic [ADDR_W-1:0] ptr;
    assign acc_addr = mbus.req_inc ? ptr : mbus.req_addr;
`else
    assign acc_addr = mbus.req_addr;
`endif

    // drv_en is async-cleared so the bus is released the moment reset asserts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            drv_en         <= 1'b0;
            mbus.req_ready <= 1'b1;
            mbus.rsp_valid <= 1'b0;
            mbus.rsp_rdata <= '0;
            mbus.bus_req   <= 1'b0;
            mbus.mem_addr  <= '0;
            mbus.mem_oe    <= 1'b0;
            mbus.mem_ie    <= 1'b0;
`ifdef MEM_BUS_MASTER_AUTOINC_EN
            ptr            <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mbus.req_valid) begin
                        we_q           <= mbus.req_we;
                        addr_q         <= acc_addr;
                        wdata_q        <= mbus.req_wdata;
                        mbus.req_ready <= 1'b0;
                        mbus.bus_req   <= 1'b1;
                        state          <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (mbus.bus_gnt) begin
                        mbus.mem_addr <= addr_q;
                        state         <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (we_q) begin
                        mbus.mem_ie <= 1'b1;
                        drv_en      <= 1'b1;
                    end else begin
                        mbus.mem_oe <= 1'b1;
                    end
                    state <= ST_XFER;
                end
                ST_XFER: begin
                    // Memory drives the bus throughout XFER on a read; sample it on the closing edge.
                    if (!we_q) mbus.rsp_rdata <= bus;
                    mbus.mem_oe    <= 1'b0;
                    mbus.mem_ie    <= 1'b0;
                    drv_en         <= 1'b0;
                    mbus.bus_req   <= 1'b0;
                    mbus.rsp_valid <= 1'b1;
                    state          <= ST_RESP;
                end
                ST_RESP: begin
                    mbus.rsp_valid <= 1'b0;
                    mbus.req_ready <= 1'b1;
`ifdef MEM_BUS_MASTER_AUTOINC_EN
                    ptr            <= addr_q + 1'b1;
`endif
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    bus_tristate_driver #(.W(DATA_W)) u_drv (
        .en  (drv_en),
        .d   (wdata_q),
        .bus (bus)
    );
endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master with a behavioural memory on the shared bus and a directly driven grant.
module tb_mem_bus_master;
    logic       clk = 1'b0;
    logic       rst;
    wire  [7:0] bus;
    logic       probe_a = 1'b0;
    logic       probe_b = 1'b0;
    logic [7:0] mem [256];
    bit         mem_init = 1'b0;
    int         cyc = 0;
    int         pass = 0;
    int         total = 0;
    int         xfer_cnt = 0;

    typedef struct {
        bit         we;
        logic [7:0] addr;
        logic [7:0] data;
        int         acc;
        int         lat;
    } exp_t;
    exp_t sb[$];

    mem_bus_master_if mbus ();

    mem_bus_master dut (
        .clk  (clk),
        .rst  (rst),
        .mbus (mbus),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory drives when enabled; otherwise a probe pattern can be forced to prove the master is off the bus.
    assign bus = mbus.mem_oe ? mem[mbus.mem_addr] : ((probe_a | probe_b) ? 8'hC3 : 8'hzz);

    function automatic logic [7:0] preset(input int a);
        case (a)
            8'hFE:   return 8'h11;
            8'hFF:   return 8'h22;
            8'h00:   return 8'h33;
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= preset(i);
            mem_init <= 1'b1;
        end else if (mbus.mem_ie) begin
            mem[mbus.mem_addr] <= bus;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Monitor: checks every memory strobe and response against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            xfer_cnt = 0;
        end else begin
            chk("oe_ie_excl", {31'b0, mbus.mem_oe & mbus.mem_ie}, 32'd0);
            if (mbus.mem_oe || mbus.mem_ie) begin
                xfer_cnt++;
                if (sb.size() == 0) chk("xfer_unexpected", 32'd1, 32'd0);
                else begin
                    chk("xfer_addr", {24'b0, mbus.mem_addr}, {24'b0, sb[0].addr});
                    chk("xfer_dir", {31'b0, mbus.mem_ie}, {31'b0, sb[0].we});
                    if (mbus.mem_ie) chk("wr_bus", {24'b0, bus}, {24'b0, sb[0].data});
                end
            end
            if (mbus.rsp_valid) begin
                if (sb.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("xfer_pulse", xfer_cnt, 32'd1);
                    if (!e.we) chk("rd_data", {24'b0, mbus.rsp_rdata}, {24'b0, e.data});
                    chk("latency", cyc - e.acc, e.lat);
                    probe_a = 1'b1;
                    #1;
                    chk("bus_z_resp", {24'b0, bus}, 32'hC3);
                    probe_a = 1'b0;
                end
                xfer_cnt = 0;
            end
        end
    end

    task automatic issue(input bit we, input logic [7:0] addr, input logic [7:0] data,
                         input logic [7:0] exp_addr, input int lat, output int acc);
        int n = 0;
        mbus.req_valid = 1'b1;
        mbus.req_we    = we;
        mbus.req_addr  = addr;
        mbus.req_wdata = data;
        @(negedge clk);
        while (!mbus.req_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!mbus.req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            mbus.req_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        sb.push_back('{we, exp_addr, data, acc, lat});
        mbus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, n;
        rst            = 1'b1;
        mbus.req_valid = 1'b0;
        mbus.req_we    = 1'b0;
        mbus.req_addr  = 8'h00;
        mbus.req_wdata = 8'h00;
        mbus.bus_gnt   = 1'b1;
`ifdef MEM_BUS_MASTER_AUTOINC_EN
        mbus.req_inc   = 1'b0;
`endif
        #2 rst = 1'b0;
        #1;
        chk("rst_req_ready", {31'b0, mbus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, mbus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {24'b0, mbus.rsp_rdata}, 32'd0);
        chk("rst_bus_req", {31'b0, mbus.bus_req}, 32'd0);
        chk("rst_mem_oe", {31'b0, mbus.mem_oe}, 32'd0);
        chk("rst_mem_ie", {31'b0, mbus.mem_ie}, 32'd0);
        chk("rst_mem_addr", {24'b0, mbus.mem_addr}, 32'd0);
        probe_b = 1'b1;
        #1;
        chk("rst_bus_z", {24'b0, bus}, 32'hC3);
        probe_b = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Write then read back with grant already high.
        issue(1'b1, 8'h10, 8'h5A, 8'h10, 3, a1);
        drain();
        chk("mem_10", {24'b0, mem[8'h10]}, 32'h5A);
        issue(1'b0, 8'h10, 8'h5A, 8'h10, 3, a1);
        drain();

        // Grant withheld: 7 cycles parked in ARB, then 3 more to the response.
        mbus.bus_gnt = 1'b0;
        issue(1'b0, 8'h10, 8'h5A, 8'h10, 10, a1);
        repeat (7) begin
            @(negedge clk);
            chk("arb_bus_req", {31'b0, mbus.bus_req}, 32'd1);
            chk("arb_no_oe_ie", {30'b0, mbus.mem_oe, mbus.mem_ie}, 32'd0);
        end
        @(posedge clk);
        #1;
        mbus.bus_gnt = 1'b1;
        drain();

        // Request held through busy with a new address: second accept waits for ready.
        issue(1'b1, 8'h30, 8'h3C, 8'h30, 3, a1);
        issue(1'b0, 8'h10, 8'h5A, 8'h10, 3, a2);
        chk("b2b_gap", a2 - a1, 32'd5);
        drain();
        issue(1'b0, 8'h30, 8'h3C, 8'h30, 3, a1);
        drain();

        // Reset during write XFER aborts the cycle.
        issue(1'b1, 8'h20, 8'h77, 8'h20, 3, a1);
        n = 0;
        @(negedge clk);
        while (!mbus.mem_ie && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_xfer", {31'b0, mbus.mem_ie}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("abort_mem_ie", {31'b0, mbus.mem_ie}, 32'd0);
        chk("abort_rsp_valid", {31'b0, mbus.rsp_valid}, 32'd0);
        chk("abort_req_ready", {31'b0, mbus.req_ready}, 32'd1);
        chk("abort_bus_req", {31'b0, mbus.bus_req}, 32'd0);
        probe_b = 1'b1;
        #1;
        chk("abort_bus_z", {24'b0, bus}, 32'hC3);
        probe_b = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        issue(1'b0, 8'h10, 8'h5A, 8'h10, 3, a1);
        drain();

`ifdef MEM_BUS_MASTER_AUTOINC_EN
        // Pointer walks 0xFE -> 0xFF -> 0x00.
        mbus.req_inc = 1'b0;
        issue(1'b0, 8'hFE, 8'h11, 8'hFE, 3, a1);
        drain();
        mbus.req_inc = 1'b1;
        issue(1'b0, 8'h55, 8'h22, 8'hFF, 3, a1);
        drain();
        issue(1'b0, 8'h55, 8'h33, 8'h00, 3, a1);
        drain();
        mbus.req_inc = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
